// File: rtl/demux_pkg.sv
// Shared types for the 1-to-2 stream demultiplexer: channel ids, buffer states, buffer depth.
package demux_pkg;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } chan_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry output buffer: mem[0] is always the head, mem[1] holds the second word when full.
module demux_fifo2
  import demux_pkg::*;
#(
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam logic [1:0] ST_EMPTY = EMPTY;
  localparam logic [1:0] ST_ONE   = ONE;
  localparam logic [1:0] ST_FULL  = FULL;

  logic [1:0]        state_p0;
  logic [DATA_W-1:0] mem_p0 [BUF_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= ST_EMPTY;
      for (int i = 0; i < BUF_DEPTH; i++) mem_p0[i] <= '0;
    end else begin
      case (state_p0)
        ST_EMPTY: begin
          if (push) begin
            mem_p0[0] <= din;
            state_p0  <= ST_ONE;
          end
        end
        ST_ONE: begin
          // Push with pop replaces the head in place; occupancy is unchanged.
          if (push && pop) begin
            mem_p0[0] <= din;
          end else if (push) begin
            mem_p0[1] <= din;
            state_p0  <= ST_FULL;
          end else if (pop) begin
            state_p0  <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // No refill while full: the caller cannot push in this state.
          if (pop) begin
            mem_p0[0] <= mem_p0[1];
            state_p0  <= ST_ONE;
          end
        end
        default: state_p0 <= ST_EMPTY;
      endcase
    end
  end

  assign full  = (state_p0 == ST_FULL);
  assign empty = (state_p0 == ST_EMPTY);
  assign head  = mem_p0[0];

endmodule

// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 valid/ready demultiplexer with a 2-entry buffer per channel.
// Optional per-channel accepted-word counters are built when DEMUX_STATS_EN is defined.
module stream_demux_1to2
  import demux_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  logic full0, full1, empty0, empty1;
  logic push0, push1, pop0, pop1;
  logic xfer;

  // Ready depends only on the selected buffer, never on in_valid.
  assign in_ready = (sel == CH1) ? !full1 : !full0;
  assign xfer     = in_valid && in_ready;
  assign push0    = xfer && (sel == CH0);
  assign push1    = xfer && (sel == CH1);
  assign pop0     = out0_valid && out0_ready;
  assign pop1     = out1_valid && out1_ready;

  demux_fifo2 #(.DATA_W(DATA_W)) u_buf0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0),
    .din   (in_data),
    .pop   (pop0),
    .full  (full0),
    .empty (empty0),
    .head  (out0_data)
  );

  demux_fifo2 #(.DATA_W(DATA_W)) u_buf1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .din   (in_data),
    .pop   (pop1),
    .full  (full1),
    .empty (empty1),
    .head  (out1_data)
  );

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt0_p0, cnt1_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_p0 <= '0;
      cnt1_p0 <= '0;
    end else begin
      if (push0) cnt0_p0 <= cnt0_p0 + CNT_W'(1);
      if (push1) cnt1_p0 <= cnt1_p0 + CNT_W'(1);
    end
  end

  assign cnt0 = cnt0_p0;
  assign cnt1 = cnt1_p0;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Bench for stream_demux_1to2: directed vector table, reset corners, counter wrap, random vs queue model.
module tb_stream_demux_1to2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_data;
  logic       sel;
  logic       out0_valid, out0_ready;
  logic [1:0] out0_data;
  logic       out1_valid, out1_ready;
  logic [1:0] out1_data;
  logic [7:0] cnt0, cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_demux_1to2 #(.DATA_W(2), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sel        (sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  typedef struct {
    logic       v;
    logic       s;
    logic [1:0] d;
    logic       r0;
    logic       r1;
    logic       rdy;
    logic       v0;
    logic [1:0] d0;
    logic       v1;
    logic [1:0] d1;
  } vec_t;

  // Reference model: one queue per channel plus plain transfer counts.
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  int         n0, n1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_cnt(input int n);
`ifdef DEMUX_STATS_EN
    return 8'(n % 256);
`else
    return 8'(n * 0);
`endif
  endfunction

  task automatic drive(input logic v, input logic s, input logic [1:0] d,
                       input logic r0, input logic r1);
    in_valid   = v;
    sel        = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    n0 = 0;
    n1 = 0;
  endtask

  // Check outputs against the model mid-cycle, then advance the model over the edge.
  task automatic model_cycle(input logic v, input logic s, input logic [1:0] d,
                             input logic r0, input logic r1);
    logic erdy, p0, p1;
    drive(v, s, d, r0, r1);
    @(negedge clk);
    erdy = s ? (q1.size() < 2) : (q0.size() < 2);
    chk("rnd_in_ready", in_ready, erdy);
    chk("rnd_out0_valid", out0_valid, q0.size() > 0);
    chk("rnd_out1_valid", out1_valid, q1.size() > 0);
    if (q0.size() > 0) chk("rnd_out0_data", out0_data, q0[0]);
    if (q1.size() > 0) chk("rnd_out1_data", out1_data, q1[0]);
    chk("rnd_cnt0", cnt0, exp_cnt(n0));
    chk("rnd_cnt1", cnt1, exp_cnt(n1));
    p0 = r0 && (q0.size() > 0);
    p1 = r1 && (q1.size() > 0);
    @(posedge clk);
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (v && erdy) begin
      if (s) begin q1.push_back(d); n1++; end
      else   begin q0.push_back(d); n0++; end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t vecs[13];

  initial begin
    // Steering, backpressure, isolation, full-with-pop and head replacement.
    vecs[0]  = '{1, 0, 2'b11, 1, 1,  1, 0, 2'b00, 0, 2'b00};
    vecs[1]  = '{1, 1, 2'b10, 1, 1,  1, 1, 2'b11, 0, 2'b00};
    vecs[2]  = '{0, 0, 2'b00, 1, 1,  1, 0, 2'b00, 1, 2'b10};
    vecs[3]  = '{0, 0, 2'b00, 1, 1,  1, 0, 2'b00, 0, 2'b00};
    vecs[4]  = '{1, 0, 2'b01, 0, 1,  1, 0, 2'b00, 0, 2'b00};
    vecs[5]  = '{1, 0, 2'b10, 0, 1,  1, 1, 2'b01, 0, 2'b00};
    vecs[6]  = '{1, 0, 2'b11, 0, 1,  0, 1, 2'b01, 0, 2'b00};
    vecs[7]  = '{1, 1, 2'b11, 0, 0,  1, 1, 2'b01, 0, 2'b00};
    vecs[8]  = '{1, 0, 2'b11, 0, 0,  0, 1, 2'b01, 1, 2'b11};
    vecs[9]  = '{1, 0, 2'b11, 1, 1,  0, 1, 2'b01, 1, 2'b11};
    vecs[10] = '{1, 0, 2'b11, 1, 1,  1, 1, 2'b10, 0, 2'b00};
    vecs[11] = '{0, 0, 2'b00, 1, 1,  1, 1, 2'b11, 0, 2'b00};
    vecs[12] = '{0, 0, 2'b00, 1, 1,  1, 0, 2'b00, 0, 2'b00};

    do_reset();

    @(negedge clk);
    chk("rst_out0_valid", out0_valid, 1'b0);
    chk("rst_out1_valid", out1_valid, 1'b0);
    chk("rst_out0_data", out0_data, 2'b00);
    chk("rst_out1_data", out1_data, 2'b00);
    chk("rst_cnt0", cnt0, 8'd0);
    chk("rst_cnt1", cnt1, 8'd0);
    sel = 1'b0; #1;
    chk("rst_in_ready_sel0", in_ready, 1'b1);
    sel = 1'b1; #1;
    chk("rst_in_ready_sel1", in_ready, 1'b1);
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].r0, vecs[i].r1);
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].rdy);
      chk($sformatf("vec%0d_out0_valid", i), out0_valid, vecs[i].v0);
      chk($sformatf("vec%0d_out1_valid", i), out1_valid, vecs[i].v1);
      if (vecs[i].v0) chk($sformatf("vec%0d_out0_data", i), out0_data, vecs[i].d0);
      if (vecs[i].v1) chk($sformatf("vec%0d_out1_data", i), out1_data, vecs[i].d1);
      @(posedge clk); #1;
    end

    // Fill both buffers, then reset asynchronously between edges.
    model_reset();
    model_cycle(1, 0, 2'b01, 0, 0);
    model_cycle(1, 0, 2'b10, 0, 0);
    model_cycle(1, 1, 2'b11, 0, 0);
    model_cycle(1, 1, 2'b01, 0, 0);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    #1;
    chk("mid_pre_out0_valid", out0_valid, 1'b1);
    chk("mid_pre_out1_valid", out1_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out0_valid", out0_valid, 1'b0);
    chk("mid_rst_out1_valid", out1_valid, 1'b0);
    chk("mid_rst_out0_data", out0_data, 2'b00);
    chk("mid_rst_out1_data", out1_data, 2'b00);
    chk("mid_rst_cnt0", cnt0, 8'd0);
    chk("mid_rst_cnt1", cnt1, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // 257 transfers to channel 1 with a ready consumer: counter wraps to 1.
    for (int i = 0; i < 257; i++) begin
      model_cycle(1, 1, 2'(i), 0, 1);
    end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("wrap_transfers", n1, 257);
    chk("wrap_cnt1", cnt1, exp_cnt(257));
    chk("wrap_cnt0", cnt0, 8'd0);
    @(posedge clk); #1;

    // Random traffic against the queue model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      model_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
